seg_counter_mux: RTL and testbench

SEG_COUNTER_MUX -- requirements
Module: seg_counter_mux

---
 rtl/seg_pkg.sv | 15 +
 rtl/seg_counter_mux_if.sv | 13 +
 rtl/seg_decoder.sv | 23 ++
 rtl/seg_counter_mux.sv | 83 ++++++++
 tb/tb_seg_counter_mux.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: segment patterns (a..g,dp with a in bit 7) and the BCD digit type.
package seg_pkg;
  typedef logic [3:0] bcd_t;
  localparam logic [7:0] SEG_0 = 8'b11111100;
  localparam logic [7:0] SEG_1 = 8'b01100000;
  localparam logic [7:0] SEG_2 = 8'b11011010;
  localparam logic [7:0] SEG_3 = 8'b11110010;
  localparam logic [7:0] SEG_4 = 8'b01100110;
  localparam logic [7:0] SEG_5 = 8'b10110110;
  localparam logic [7:0] SEG_6 = 8'b10111110;
  localparam logic [7:0] SEG_7 = 8'b11100000;
  localparam logic [7:0] SEG_8 = 8'b11111110;
  localparam logic [7:0] SEG_9 = 8'b11100110;
  localparam logic [7:0] SEG_BLANK = 8'b00000000;
endpackage

// File: rtl/seg_counter_mux_if.sv
// seg_counter_mux_if: counter control inputs and display/count outputs.
interface seg_counter_mux_if #(parameter int N_DIGITS = 4);
  logic count_en;
  logic up_dn;
  logic load;
  logic [4*N_DIGITS-1:0] load_val;
  logic [4*N_DIGITS-1:0] count_bcd;
  logic wrap;
  logic [7:0] seg;
  logic [N_DIGITS-1:0] an;
  modport master(output count_en, up_dn, load, load_val, input count_bcd, wrap, seg, an);
  modport slave(input count_en, up_dn, load, load_val, output count_bcd, wrap, seg, an);
endinterface

// File: rtl/seg_decoder.sv
// seg_decoder: BCD digit to seven-segment pattern; non-decimal values go dark.
module seg_decoder
  import seg_pkg::*;
(
  input  bcd_t       d,
  output logic [7:0] seg
);
  always_comb begin
    case (d)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seg_counter_mux.sv
// seg_counter_mux: prescaled BCD up/down counter with multiplexed 7-seg scan.
// Define SEG_LZB_EN to blank leading zero digits.
module seg_counter_mux
  import seg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int TICK_DIV = 1000,
  parameter int SCAN_DIV = 16
) (
  input logic clk,
  input logic rst_n,
  seg_counter_mux_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  logic [PW-1:0] pre;
  logic [SW-1:0] sc;
  logic [IW-1:0] idx;
  logic [4*N_DIGITS-1:0] cnt, nxt, ld;
  logic tick, cy, wrap_r, adv, slot_end, blank;
  logic [7:0] seg_r, dec;
  logic [N_DIGITS-1:0] an_r;
  bcd_t sel;
  assign tick = bus.count_en && pre == PW'(TICK_DIV - 1);
  // cy carries (up) or borrows (down) from digit 0 upward; its final value flags wrap
  always_comb begin
    nxt = cnt;
    ld = bus.load_val;
    cy = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bus.load_val[4*i+:4] > 4'd9) ld[4*i+:4] = 4'd0;
      if (cy) nxt[4*i+:4] = bus.up_dn ? (cnt[4*i+:4] == 4'd9 ? 4'd0 : cnt[4*i+:4] + 4'd1)
                                      : (cnt[4*i+:4] == 4'd0 ? 4'd9 : cnt[4*i+:4] - 4'd1);
      cy = cy && (bus.up_dn ? cnt[4*i+:4] == 4'd9 : cnt[4*i+:4] == 4'd0);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      cnt <= '0;
      wrap_r <= 1'b0;
    end else if (bus.load) begin
      pre <= '0;
      cnt <= ld;
      wrap_r <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + PW'(bus.count_en);
      if (tick) cnt <= nxt;
      wrap_r <= tick && cy;
    end
  end
  assign slot_end = sc == SW'(SCAN_DIV - 1);
  assign sel = cnt[{idx, 2'b00} +: 4];
`ifdef SEG_LZB_EN
  assign blank = idx != '0 && (cnt >> {idx, 2'b00}) == '0;
`else
  assign blank = 1'b0;
`endif
  seg_decoder u_dec (.d(sel), .seg(dec));
  // seg/an latch the new index one clock after it advances, so they change only at slot boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc <= '0;
      idx <= '0;
      adv <= 1'b0;
      seg_r <= SEG_0;
      an_r <= N_DIGITS'(1);
    end else begin
      sc <= slot_end ? '0 : sc + SW'(1);
      adv <= slot_end;
      if (slot_end) idx <= idx == IW'(N_DIGITS - 1) ? '0 : idx + IW'(1);
      if (adv) begin
        an_r <= N_DIGITS'(1) << idx;
        seg_r <= blank ? SEG_BLANK : dec;
      end
    end
  end
  assign bus.count_bcd = cnt;
  assign bus.wrap = wrap_r;
  assign bus.seg = seg_r;
  assign bus.an = an_r;
endmodule

// File: tb/tb_seg_counter_mux.sv
// tb_seg_counter_mux: random and directed stimulus scored against an arithmetic model.
module tb_seg_counter_mux;
  localparam int ND = 4, TD = 4, SD = 2;
`ifdef SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  typedef struct {
    logic [15:0] cnt;
    logic        w;
    logic [7:0]  seg;
    logic [3:0]  an;
  } exp_t;
  logic clk, rst_n;
  int checks = 0, errors = 0;
  int val, prev, pc, m, di;
  logic ew;
  logic [7:0] eseg;
  logic [3:0] ean;
  exp_t q[$];
  seg_counter_mux_if #(.N_DIGITS(ND)) bus ();
  seg_counter_mux #(.N_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic int p10(int i);
    int r = 1;
    for (int k = 0; k < i; k++) r *= 10;
    return r;
  endfunction
  function automatic logic [7:0] pat(int d);
    logic [7:0] t [10] = '{8'b11111100, 8'b01100000, 8'b11011010, 8'b11110010, 8'b01100110,
                           8'b10110110, 8'b10111110, 8'b11100000, 8'b11111110, 8'b11100110};
    return t[d];
  endfunction
  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    for (int i = 0; i < ND; i++) r[4*i+:4] = 4'((v / p10(i)) % 10);
    return r;
  endfunction
  function automatic int from_ld(logic [15:0] lv);
    int v = 0;
    for (int i = 0; i < ND; i++) v += (lv[4*i+:4] > 9 ? 0 : int'(lv[4*i+:4])) * p10(i);
    return v;
  endfunction
  function automatic void chk(string n, logic [31:0] a, logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, a, x, $time);
    end
  endfunction
  // Reference model: count as an integer, display slot derived from edges since reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val = 0; pc = 0; m = 0; ew = 1'b0; eseg = 8'b11111100; ean = 4'b0001;
      q.delete();
    end else begin
      prev = val;
      m++;
      ew = 1'b0;
      if (bus.load) begin
        val = from_ld(bus.load_val);
        pc = 0;
      end else if (bus.count_en) begin
        if (pc == TD - 1) begin
          pc = 0;
          if (bus.up_dn) begin
            ew = val == p10(ND) - 1;
            val = ew ? 0 : val + 1;
          end else begin
            ew = val == 0;
            val = ew ? p10(ND) - 1 : val - 1;
          end
        end else pc++;
      end
      if (m > 1 && (m - 1) % SD == 0) begin
        di = ((m - 1) / SD) % ND;
        ean = 4'(1 << di);
        eseg = (LZB && di > 0 && prev / p10(di) == 0) ? 8'h00 : pat((prev / p10(di)) % 10);
      end
      q.push_back('{to_bcd(val), ew, eseg, ean});
    end
  end
  always @(negedge clk) begin
    if (rst_n && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("count_bcd", 32'(bus.count_bcd), 32'(e.cnt));
      chk("wrap", 32'(bus.wrap), 32'(e.w));
      chk("seg", 32'(bus.seg), 32'(e.seg));
      chk("an", 32'(bus.an), 32'(e.an));
    end
  end
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_load(logic [15:0] v);
    bus.load = 1'b1;
    bus.load_val = v;
    step(1);
    bus.load = 1'b0;
  endtask
  task automatic reset_checks(string tag);
    chk({tag, "_count"}, 32'(bus.count_bcd), 32'h0);
    chk({tag, "_wrap"}, 32'(bus.wrap), 32'h0);
    chk({tag, "_seg"}, 32'(bus.seg), 32'hFC);
    chk({tag, "_an"}, 32'(bus.an), 32'h1);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.count_en = 1'b0; bus.up_dn = 1'b1; bus.load = 1'b0; bus.load_val = '0;
    repeat (2) @(posedge clk);
    #1 reset_checks("rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    bus.count_en = 1'b1;
    do_load(16'h9998);
    step(10);
    bus.up_dn = 1'b0;
    do_load(16'h0000);
    step(10);
    bus.up_dn = 1'b1;
    for (int i = 0; i < TD && pc != TD - 1; i++) step(1);
    do_load(16'h12F4);
    step(3);
    bus.count_en = 1'b0;
    do_load(16'h0305);
    step(20);
    do_load(16'h0007);
    bus.count_en = 1'b1;
    step(2);
    bus.count_en = 1'b0;
    step(10);
    bus.count_en = 1'b1;
    step(5);
    do_load(16'h0042);
    step(2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 reset_checks("async_rst");
    #1 rst_n = 1'b1;
    step(12);
    repeat (400) begin
      bus.load = $urandom_range(9) == 0;
      bus.load_val = 16'($urandom);
      bus.count_en = $urandom_range(4) != 0;
      bus.up_dn = 1'($urandom);
      step(1);
    end
    bus.load = 1'b0;
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
